video_pll_sequencer: RTL

//  Power-up/recovery sequencer for the video PLL, running on the 50 MHz refclk domain.

---
 rtl/video_pll_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/video_pll_sequencer.sv
// Video PLL power-up/recovery sequencer: PLL reset, lock wait with timeout/retry, stable qualification, downstream release.
// Optional build macro PLL_LOSS_CNT_EN adds a saturating counter of lock losses seen in RUN.
module video_pll_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 16
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       restart,
    input  logic       locked,
    output logic       pll_rst,
    output logic       domain_rst,
    output logic       ready,
    output logic       fail,
    output logic [2:0] state,
    output logic [7:0] loss_cnt
);

    typedef enum logic [2:0] {
        ST_HOLD   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAIL   = 3'd4
    } state_e;

    localparam int RET_W = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RET_W-1:0] RET_ONE     = RET_W'(1);
    localparam logic [RET_W-1:0] RET_MAX     = RET_W'(MAX_RETRIES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RET_W-1:0] retries_q, retries_d;
    logic [1:0]       sync_q, sync_d;
    logic             lock_s;
    logic             pll_rst_q, pll_rst_d;
    logic             domain_rst_q, domain_rst_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;

    // locked is asynchronous to refclk; bit 1 is the qualified copy.
    always_comb begin
        sync_d = {sync_q[0], locked};
    end
    assign lock_s = sync_q[1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retries_d = retries_q;
        if (restart) begin
            state_d   = ST_HOLD;
            cnt_d     = '0;
            retries_d = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_WAIT: begin
                    if (lock_s) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_LAST) begin
                        retries_d = retries_q + RET_ONE;
                        cnt_d     = '0;
                        state_d   = (retries_d == RET_MAX) ? ST_FAIL : ST_HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_STABLE: begin
                    // A drop here restarts the full timeout but is not counted as a retry.
                    if (!lock_s) begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d   = ST_RUN;
                        cnt_d     = '0;
                        retries_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d   = ST_HOLD;
                    cnt_d     = '0;
                    retries_d = '0;
                end
            endcase
        end
    end

    // Outputs decode the next state so they flip on the same edge as the state register.
    always_comb begin
        pll_rst_d    = (state_d == ST_HOLD) || (state_d == ST_FAIL);
        domain_rst_d = (state_d != ST_RUN);
        ready_d      = (state_d == ST_RUN);
        fail_d       = (state_d == ST_FAIL);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q      <= ST_HOLD;
            cnt_q        <= '0;
            retries_q    <= '0;
            sync_q       <= 2'b00;
            pll_rst_q    <= 1'b1;
            domain_rst_q <= 1'b1;
            ready_q      <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retries_q    <= retries_d;
            sync_q       <= sync_d;
            pll_rst_q    <= pll_rst_d;
            domain_rst_q <= domain_rst_d;
            ready_q      <= ready_d;
            fail_q       <= fail_d;
        end
    end

    assign pll_rst    = pll_rst_q;
    assign domain_rst = domain_rst_q;
    assign ready      = ready_q;
    assign fail       = fail_q;
    assign state      = state_q;

`ifdef PLL_LOSS_CNT_EN
    logic [7:0] loss_cnt_q, loss_cnt_d;
    logic       loss_evt;

    // restart out of RUN is an operator action, not a lock loss.
    assign loss_evt = (state_q == ST_RUN) && (state_d == ST_HOLD) && !restart;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (loss_evt && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            loss_cnt_q <= 8'd0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign loss_cnt = loss_cnt_q;
`else
    assign loss_cnt = 8'd0;
`endif

endmodule
